imm_operand_stage: RTL and testbench
====================================

# imm_operand_stage

Registered operand-B stage for the RV32/RV64 datapath: decodes all immediate formats from the raw instruction word, or passes the rs2 register value, into an XLEN-wide ALU operand. It sits between register read and the ALU and carries a valid/ready handshake with a two-entry skid buffer, so decode and execute decouple under stalls. It replaces the fixed-width, unhandshaked extender with a parametrised, sign-correct, backpressure-safe stage.

## Interface
- XLEN, 32: operand width; legal values 32 or 64.
- SIGN_EXT, 1: 1 = RISC-V sign extension from the immediate MSB; 0 = zero extension (legacy LUI/LW bring-up mode).
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  upstream has a request.
- in_ready  out  1  stage can accept a request this cycle.
- in_instr  in  32  raw instruction word.
- in_sel  in  3  operand select (op_sel_t).
- in_rs2  in  XLEN  rs2 read data.
- out_valid  out  1  out_operand valid.
- out_ready  in  1  ALU consumes this cycle.
- out_operand  out  XLEN  selected/extended operand.
- out_sel  out  3  in_sel that produced out_operand, for debug/forwarding.

## Operation
- Transfer on a port occurs when valid && ready on the same rising edge.
- op_sel_t encodings and results, with ext() meaning sign or zero extension per SIGN_EXT:
  - 0 RS2: in_rs2.
  - 1 IMM_I: ext(instr[31:20]).
  - 2 IMM_S: ext({instr[31:25], instr[11:7]}).
  - 3 IMM_B: ext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 4 IMM_U: {instr[31:12], 12'b0}, sign-extended to XLEN when XLEN=64 and SIGN_EXT=1.
  - 5 IMM_J: ext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 6 SHAMT: zero-extended instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
  - 7 ZERO: all zeros.
- The operand is computed combinationally from the input, then captured into the output register or the skid register.
- Buffer states:
  - EMPTY: out_valid=0.
  - ONE: output register valid, skid empty.
  - FULL: output and skid both valid; in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept and no drain -> FULL.
  - ONE + drain and no accept -> EMPTY.
  - ONE + accept and drain -> ONE, output register reloaded from the input.
  - FULL + drain -> ONE, skid contents move to the output register.
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Output order equals acceptance order; no request is lost or duplicated.
- Reset values: out_valid=0, out_operand=0, out_sel=0, skid cleared. in_ready=1 from the first cycle after reset release.
- Reset mid-operation: buffered requests are discarded with no drain. While rst_n=0, input transfers are ignored.

## Timing
- Latency 1 cycle: a request accepted at edge N is on out_operand with out_valid=1 after edge N.
- Throughput 1 per cycle while out_ready=1.
- A stall of k cycles absorbs at most 2 requests. in_ready falls after the second accept with no drain.
- A simultaneous accept and drain in ONE keeps the stage in ONE with no bubble.
- out_operand and out_sel stay stable while out_valid=1 && out_ready=0.
- Illegal sel values cannot occur because the field is 3 bits and all 8 codes are defined.

## Structure
- Shared package rv_operand_pkg holds op_sel_t, the immediate field bit positions, and the XLEN-dependent SHAMT width function. The ALU and decoder import the same package.
- One sub-module, imm_decode: purely combinational; ports instr, sel, rs2 -> operand; parametrised by XLEN and SIGN_EXT.
- The top level holds the output register, skid register and the handshake.

## Test plan
- IMM_I, XLEN=32, SIGN_EXT=1, instr 0xFFF00093 -> out_operand 0xFFFFFFFF one cycle later. Same with SIGN_EXT=0 -> 0x00000FFF.
- IMM_S instr 0x00112623 -> 0x0000000C. IMM_B instr 0xFE000EE3 -> 0xFFFFFFFC. IMM_U instr 0x12345037 -> 0x12345000.
- SHAMT instr 0x4030D093 -> 0x00000003. RS2 with in_rs2=0xDEADBEEF -> 0xDEADBEEF. XLEN=64 IMM_I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
- Backpressure: out_ready=0 while streaming sel RS2 with rs2 = 1, 2, 3.
  - Only 1 and 2 are accepted; in_ready=0 afterwards.
  - Raising out_ready then delivers 1, 2, 3 on consecutive cycles with no bubble.
- Full throughput: out_ready=1, 100 back-to-back random requests -> 100 outputs in order, each matching the reference model, one cycle apart.
- Reset with FULL buffer: assert rst_n=0 for one cycle -> out_valid=0 next cycle and in_ready=1 after release; no stale operand appears.

Source files
------------

// File: rtl/rv_operand_pkg.sv
// Shared operand-select encodings, immediate field positions and SHAMT sizing
// used by the decoder, ALU and the operand-B stage.
package rv_operand_pkg;

    typedef enum logic [2:0] {
        SEL_RS2   = 3'd0,
        SEL_IMM_I = 3'd1,
        SEL_IMM_S = 3'd2,
        SEL_IMM_B = 3'd3,
        SEL_IMM_U = 3'd4,
        SEL_IMM_J = 3'd5,
        SEL_SHAMT = 3'd6,
        SEL_ZERO  = 3'd7
    } op_sel_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    localparam int IMM_SIGN_BIT = 31;
    localparam int IMM_I_LSB    = 20;
    localparam int IMM_HI_LSB   = 25;
    localparam int IMM_LO_LSB   = 7;
    localparam int IMM_U_LSB    = 12;
    localparam int SHAMT_LSB    = 20;

    // RV64 shifts use a 6-bit amount, RV32 a 5-bit one.
    function automatic int shamt_width(input int xlen);
        if (xlen == 64) begin
            return 6;
        end else begin
            return 5;
        end
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational operand-B selector: extends every RISC-V immediate format from
// the raw instruction word, or forwards rs2, to an XLEN-wide operand.
module imm_decode
    import rv_operand_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic [31:0]     instr,
    input  op_sel_t         sel,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] operand
);

    localparam int SHW = shamt_width(XLEN);

    logic fill_s;
    logic unused_opcode_s;

    // Every format keeps its sign in instr[31]; in zero-extend mode the fill is 0.
    assign fill_s          = SIGN_EXT ? instr[IMM_SIGN_BIT] : 1'b0;
    assign unused_opcode_s = ^instr[6:0];

    // Immediates are built 64 bits wide and then cut to XLEN, so XLEN=32 simply
    // drops the upper fill and U stays unextended there.
    always_comb begin
        operand = {XLEN{1'b0}};
        case (sel)
            SEL_RS2:   operand = rs2;
            SEL_IMM_I: operand = XLEN'({{52{fill_s}}, instr[31:IMM_I_LSB]});
            SEL_IMM_S: operand = XLEN'({{52{fill_s}}, instr[31:IMM_HI_LSB],
                                        instr[11:IMM_LO_LSB]});
            SEL_IMM_B: operand = XLEN'({{51{fill_s}}, instr[31], instr[7],
                                        instr[30:25], instr[11:8], 1'b0});
            SEL_IMM_U: operand = XLEN'({{32{fill_s}}, instr[31:IMM_U_LSB], 12'b0});
            SEL_IMM_J: operand = XLEN'({{43{fill_s}}, instr[31], instr[19:12],
                                        instr[20], instr[30:21], 1'b0});
            SEL_SHAMT: operand = XLEN'(instr[SHAMT_LSB +: SHW]);
            SEL_ZERO:  operand = {XLEN{1'b0}};
            default:   operand = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/imm_operand_stage.sv
// Registered operand-B stage: decodes the operand and hands it to the ALU through
// a valid/ready interface backed by an output register plus one skid entry.
module imm_operand_stage
    import rv_operand_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_sel,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_operand,
    output logic [2:0]      out_sel
);

    buf_state_t      state_r;
    buf_state_t      state_next_s;
    logic            out_valid_r;
    logic            in_ready_r;
    logic [XLEN-1:0] out_operand_r;
    logic [2:0]      out_sel_r;
    logic [XLEN-1:0] skid_operand_r;
    logic [2:0]      skid_sel_r;
    logic [XLEN-1:0] dec_operand_s;
    logic            accept_s;
    logic            drain_s;
    logic            load_out_in_s;
    logic            load_out_skid_s;
    logic            load_skid_s;

    imm_decode #(
        .XLEN     (XLEN),
        .SIGN_EXT (SIGN_EXT)
    ) u_decode (
        .instr   (in_instr),
        .sel     (op_sel_t'(in_sel)),
        .rs2     (in_rs2),
        .operand (dec_operand_s)
    );

    assign accept_s    = in_valid && in_ready_r;
    assign drain_s     = out_valid_r && out_ready;
    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_operand = out_operand_r;
    assign out_sel     = out_sel_r;

    // Next buffer state and which register captures data this cycle.
    always_comb begin
        state_next_s    = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_r)
            BUF_EMPTY: begin
                if (accept_s) begin
                    state_next_s  = BUF_ONE;
                    load_out_in_s = 1'b1;
                end else begin
                    state_next_s = BUF_EMPTY;
                end
            end
            BUF_ONE: begin
                if (accept_s && drain_s) begin
                    load_out_in_s = 1'b1;
                end else if (accept_s) begin
                    state_next_s = BUF_FULL;
                    load_skid_s  = 1'b1;
                end else if (drain_s) begin
                    state_next_s = BUF_EMPTY;
                end else begin
                    state_next_s = BUF_ONE;
                end
            end
            BUF_FULL: begin
                // in_ready is low here, so no accept can coincide with the drain.
                if (drain_s) begin
                    state_next_s    = BUF_ONE;
                    load_out_skid_s = 1'b1;
                end else begin
                    state_next_s = BUF_FULL;
                end
            end
            default: state_next_s = BUF_EMPTY;
        endcase
    end

    // State, handshake flags and data registers; in_ready is precomputed so it
    // never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= BUF_EMPTY;
            out_valid_r    <= 1'b0;
            in_ready_r     <= 1'b1;
            out_operand_r  <= {XLEN{1'b0}};
            out_sel_r      <= 3'd0;
            skid_operand_r <= {XLEN{1'b0}};
            skid_sel_r     <= 3'd0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s != BUF_EMPTY);
            in_ready_r  <= (state_next_s != BUF_FULL);
            if (load_out_in_s) begin
                out_operand_r <= dec_operand_s;
                out_sel_r     <= in_sel;
            end else if (load_out_skid_s) begin
                out_operand_r <= skid_operand_r;
                out_sel_r     <= skid_sel_r;
            end
            if (load_skid_s) begin
                skid_operand_r <= dec_operand_s;
                skid_sel_r     <= in_sel;
            end
        end
    end

endmodule

// File: tb/tb_imm_operand_stage.sv
// Directed bench for imm_operand_stage: immediate decode in three parameter
// flavours, backpressure, full-rate streaming and reset with a full buffer.
module tb_imm_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_sel;
    logic [31:0] in_rs2_32;
    logic [63:0] in_rs2_64;
    logic        out_ready;

    logic        rdy_a, val_a, rdy_b, val_b, rdy_c, val_c;
    logic [31:0] op_a, op_b;
    logic [63:0] op_c;
    logic [2:0]  sel_a, sel_b, sel_c;

    integer errors = 0;
    integer checks = 0;

    // a: RV32 sign-extend, b: RV32 zero-extend, c: RV64 sign-extend
    imm_operand_stage #(.XLEN(32), .SIGN_EXT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_instr(in_instr), .in_sel(in_sel), .in_rs2(in_rs2_32),
        .out_valid(val_a), .out_ready(out_ready), .out_operand(op_a), .out_sel(sel_a)
    );
    imm_operand_stage #(.XLEN(32), .SIGN_EXT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_instr(in_instr), .in_sel(in_sel), .in_rs2(in_rs2_32),
        .out_valid(val_b), .out_ready(out_ready), .out_operand(op_b), .out_sel(sel_b)
    );
    imm_operand_stage #(.XLEN(64), .SIGN_EXT(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
        .in_instr(in_instr), .in_sel(in_sel), .in_rs2(in_rs2_64),
        .out_valid(val_c), .out_ready(out_ready), .out_operand(op_c), .out_sel(sel_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NV = 11;
    localparam logic [31:0] V_INSTR [NV] = '{
        32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h12345037, 32'h80000037,
        32'hFFDFF06F, 32'h4030D093, 32'h03F01013, 32'h00000000, 32'hFFFFFFFF,
        32'h7FF00093};
    localparam logic [2:0] V_SEL [NV] = '{
        3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd6, 3'd0, 3'd7, 3'd1};
    localparam logic [63:0] V_RS2 [NV] = '{
        64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
        64'hCAFEF00DDEADBEEF, 64'h0, 64'h0};
    localparam logic [31:0] V_EXP_A [NV] = '{
        32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h12345000, 32'h80000000,
        32'hFFFFFFFC, 32'h00000003, 32'h0000001F, 32'hDEADBEEF, 32'h00000000,
        32'h000007FF};
    localparam logic [31:0] V_EXP_B [NV] = '{
        32'h00000FFF, 32'h0000000C, 32'h00001FFC, 32'h12345000, 32'h80000000,
        32'h001FFFFC, 32'h00000003, 32'h0000001F, 32'hDEADBEEF, 32'h00000000,
        32'h000007FF};
    localparam logic [63:0] V_EXP_C [NV] = '{
        64'hFFFFFFFFFFFFFFFF, 64'h000000000000000C, 64'hFFFFFFFFFFFFFFFC,
        64'h0000000012345000, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
        64'h0000000000000003, 64'h000000000000003F, 64'hCAFEF00DDEADBEEF,
        64'h0000000000000000, 64'h00000000000007FF};

    // Independent RV32 sign-extending reference for the random stream.
    function automatic logic [31:0] ref32(input logic [31:0] i, input logic [2:0] s,
                                          input logic [31:0] r);
        logic [31:0] v;
        case (s)
            3'd0: v = r;
            3'd1: v = {{20{i[31]}}, i[31:20]};
            3'd2: v = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4: v = {i[31:12], 12'h000};
            3'd5: v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd6: v = {27'd0, i[24:20]};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_sel = 3'd1;
        in_rs2_32 = 32'd0; in_rs2_64 = 64'd0; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (val_a !== 1'b0 || op_a !== 32'd0 || sel_a !== 3'd0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b op=%h sel=%0d rdy=%b expected 0 0 0 1",
                     val_a, op_a, sel_a, rdy_a);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (val_a !== 1'b0 || rdy_a !== 1'b1 || val_c !== 1'b0) begin
            errors++;
            $display("FAIL after_release: got v=%b rdy=%b v64=%b expected 0 1 0",
                     val_a, rdy_a, val_c);
        end
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            in_valid = 1'b1; in_instr = V_INSTR[k]; in_sel = V_SEL[k];
            in_rs2_64 = V_RS2[k]; in_rs2_32 = V_RS2[k][31:0];
            tick();
            checks++;
            if (val_a !== 1'b1 || op_a !== V_EXP_A[k] || sel_a !== V_SEL[k]) begin
                errors++;
                $display("FAIL decode32s[%0d]: got v=%b op=%h sel=%0d expected 1 %h %0d",
                         k, val_a, op_a, sel_a, V_EXP_A[k], V_SEL[k]);
            end
            checks++;
            if (val_b !== 1'b1 || op_b !== V_EXP_B[k]) begin
                errors++;
                $display("FAIL decode32z[%0d]: got v=%b op=%h expected 1 %h",
                         k, val_b, op_b, V_EXP_B[k]);
            end
            checks++;
            if (val_c !== 1'b1 || op_c !== V_EXP_C[k]) begin
                errors++;
                $display("FAIL decode64[%0d]: got v=%b op=%h expected 1 %h",
                         k, val_c, op_c, V_EXP_C[k]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (val_a !== 1'b0) begin
            errors++;
            $display("FAIL decode_idle: got out_valid=%b expected 0", val_a);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_seq [3] = '{32'd1, 32'd2, 32'd3};
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd0; in_rs2_32 = 32'd1;
        tick();
        in_rs2_32 = 32'd2;
        tick();
        checks++;
        if (rdy_a !== 1'b0 || val_a !== 1'b1 || op_a !== 32'd1) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b v=%b op=%h expected 0 1 00000001",
                     rdy_a, val_a, op_a);
        end
        in_rs2_32 = 32'd3;
        tick(); tick();
        checks++;
        if (rdy_a !== 1'b0 || val_a !== 1'b1 || op_a !== 32'd1 || sel_a !== 3'd0) begin
            errors++;
            $display("FAIL bp_stall_stable: got rdy=%b v=%b op=%h expected 0 1 00000001",
                     rdy_a, val_a, op_a);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            if (k == 2) in_valid = 1'b0;
            checks++;
            if (val_a !== 1'b1 || op_a !== exp_seq[k]) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got v=%b op=%h expected 1 %h",
                         k, val_a, op_a, exp_seq[k]);
            end
        end
        tick();
        checks++;
        if (val_a !== 1'b0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty: got v=%b rdy=%b expected 0 1", val_a, rdy_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins, rs, exp;
        logic [2:0]  sl;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            ins = $urandom; rs = $urandom; sl = 3'($urandom_range(0, 7));
            exp = ref32(ins, sl, rs);
            in_valid = 1'b1; in_instr = ins; in_sel = sl; in_rs2_32 = rs;
            in_rs2_64 = {32'd0, rs};
            tick();
            checks++;
            if (val_a !== 1'b1 || rdy_a !== 1'b1 || op_a !== exp || sel_a !== sl) begin
                errors++;
                $display("FAIL stream[%0d]: got v=%b rdy=%b op=%h sel=%0d expected 1 1 %h %0d",
                         k, val_a, rdy_a, op_a, sel_a, exp, sl);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd0; in_rs2_32 = 32'hAAAA0001;
        tick();
        in_rs2_32 = 32'hAAAA0002;
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (val_a !== 1'b0 || rdy_a !== 1'b1 || op_a !== 32'd0) begin
            errors++;
            $display("FAIL rst_full: got v=%b rdy=%b op=%h expected 0 1 00000000",
                     val_a, rdy_a, op_a);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (val_a !== 1'b0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_stale: got v=%b rdy=%b expected 0 1", val_a, rdy_a);
        end
        in_valid = 1'b1; in_sel = 3'd1; in_instr = 32'hFFF00093;
        tick();
        in_valid = 1'b0;
        checks++;
        if (val_a !== 1'b1 || op_a !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL rst_resume: got v=%b op=%h expected 1 ffffffff", val_a, op_a);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_back_to_back();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
